countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 100, giving the number of clk cycles per counted second; legal range 2..65535.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports as listed below.
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port clear_  input  1  synchronous active-low clear from keypad.
REQ-006 Port digit_valid  input  1  single-cycle strobe, keypad digit present.
REQ-007 Port digit  input  4  keypad digit, BCD.
REQ-008 Port mag_on  input  1  magnetron running; enables countdown.
REQ-009 Port min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed time, BCD.
REQ-010 Port timer_done  output  1  countdown reached 00:00; drives the magnetron control stage.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE, a digit_valid with digit<=9 SHALL shift the digits left one place (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit) on the same edge.
REQ-013 A digit_valid with digit>9 SHALL be ignored; digit_valid SHALL be ignored in RUN.
REQ-014 IDLE->RUN SHALL occur on the edge where mag_on=1 and the time is non-zero; with mag_on=1 and time 00:00, IDLE->DONE on that edge.
REQ-015 In RUN, a prescaler SHALL count clk cycles while mag_on=1 and SHALL hold its value while mag_on=0 (pause); the state SHALL stay RUN while paused.
REQ-016 When the prescaler reaches TICK_DIV-1, it SHALL wrap to 0 and the time SHALL decrement by one second on that edge.
REQ-017 Decrement rules: sec_ones 0->9 with borrow; sec_tens with borrow 0->5 and further borrow; min_ones 0->9 with borrow; min_tens decrements on borrow. Non-borrowing digits SHALL decrement by 1.
REQ-018 Entered sec_tens values 6..9 SHALL be counted down unchanged until they borrow (e.g. 00:75 passes 00:70 then 00:69).
REQ-019 The decrement producing 00:00 SHALL move RUN->DONE on the same edge; timer_done SHALL be 1 from the following cycle.
REQ-020 timer_done SHALL be 1 exactly while in DONE; it SHALL be a registered output.
REQ-021 In DONE the time SHALL stay 00:00 and mag_on SHALL be ignored; a valid digit_valid SHALL shift in the digit as in REQ-012 and move DONE->IDLE.
REQ-022 clear_=0 SHALL, on the next edge and with priority over all other inputs, zero all digits and the prescaler and enter IDLE.
REQ-023 Leaving RUN by clear_ SHALL zero the prescaler; re-entering RUN SHALL always start the prescaler from 0.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, all four digits to 0, prescaler to 0 and timer_done to 0, independent of clk.
REQ-025 Reset deassertion mid-operation SHALL resume from IDLE with no residual count; no output SHALL glitch high during reset.

Structure
REQ-026 The state enumeration (IDLE, RUN, DONE) and the TICK_DIV default SHALL live in the shared package microwave_pkg.
REQ-027 One sub-module bcd_digit_dec SHALL implement a single BCD digit decrement: inputs value, wrap value (9 or 5), borrow_in; outputs next value, borrow_out; instantiated four times.
REQ-028 The prescaler width SHALL be 16 bits; no arithmetic on the digits SHALL be done outside bcd_digit_dec.

Verification (TICK_DIV=4)
REQ-029 Reset, enter digits 1,3,0 -> display 01:30, timer_done=0, state IDLE.
REQ-030 01:30 loaded, mag_on=1 for 4 cycles -> display 01:29; after 8 more cycles -> 01:27.
REQ-031 Load 00:01, mag_on=1 -> 00:00 after 4 cycles, timer_done=1 the next cycle, held while mag_on toggles.
REQ-032 Load 10:00, run to 09:59 -> check borrow chain through all four digits in one edge.
REQ-033 RUN at 00:05, mag_on=0 after 2 prescaler cycles for 10 cycles, then mag_on=1 -> decrement occurs 2 cycles after resume.
REQ-034 clear_=0 and digit_valid together in DONE -> display 00:00, IDLE, timer_done=0; rst_n pulse mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave oven control blocks.
// Holds the timer state encoding, the packed display time and the tick default.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int TICK_DIV_DEFAULT = 100;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] WRAP_ONES = 4'd9;
    localparam logic [3:0] WRAP_TENS = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } disp_t;

    function automatic logic is_zero(input disp_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown: passes through unless borrowed from,
// then steps down by one or wraps to the given value and borrows onward.
module bcd_digit_dec (
    input  logic [3:0] value_i,
    input  logic [3:0] wrap_i,
    input  logic       borrow_in_i,
    output logic [3:0] next_o,
    output logic       borrow_out_o
);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_o       = value_i;
        borrow_out_o = 1'b0;
        if (borrow_in_i) begin
            if (value_i == 4'd0) begin
                next_o       = wrap_i;
                borrow_out_o = 1'b1;
            end else begin
                next_o = value_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Microwave countdown timer: keypad entry of MM:SS, one-second countdown
// while the magnetron runs, and a registered done flag at 00:00.
module countdown_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_e      state_q, state_d;
    disp_t       disp_q, disp_d;
    logic [15:0] presc_q, presc_d;
    logic        timer_done_q;

    disp_t       dec;
    disp_t       shifted;
    logic        digit_ok;
    logic        b_sec_ones, b_sec_tens, b_min_ones, dec_underflow;

    bcd_digit_dec u_dec_sec_ones (
        .value_i      (disp_q.sec_ones),
        .wrap_i       (WRAP_ONES),
        .borrow_in_i  (1'b1),
        .next_o       (dec.sec_ones),
        .borrow_out_o (b_sec_ones)
    );

    // Entered tens-of-seconds 6..9 simply count down; only a borrow from 0 wraps to 5.
    bcd_digit_dec u_dec_sec_tens (
        .value_i      (disp_q.sec_tens),
        .wrap_i       (WRAP_TENS),
        .borrow_in_i  (b_sec_ones),
        .next_o       (dec.sec_tens),
        .borrow_out_o (b_sec_tens)
    );

    bcd_digit_dec u_dec_min_ones (
        .value_i      (disp_q.min_ones),
        .wrap_i       (WRAP_ONES),
        .borrow_in_i  (b_sec_tens),
        .next_o       (dec.min_ones),
        .borrow_out_o (b_min_ones)
    );

    bcd_digit_dec u_dec_min_tens (
        .value_i      (disp_q.min_tens),
        .wrap_i       (WRAP_ONES),
        .borrow_in_i  (b_min_ones),
        .next_o       (dec.min_tens),
        .borrow_out_o (dec_underflow)
    );

    assign digit_ok = digit_valid && (digit <= DIGIT_MAX);
    assign shifted  = {disp_q.min_ones, disp_q.sec_tens, disp_q.sec_ones, digit};

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        presc_d = presc_q;
        if (!clear_) begin
            state_d = IDLE;
            disp_d  = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mag_on) begin
                        presc_d = '0;
                        state_d = is_zero(disp_q) ? DONE : RUN;
                    end else if (digit_ok) begin
                        disp_d = shifted;
                    end
                end
                RUN: begin
                    // Paused (mag_on low) holds both the prescaler and the time.
                    if (mag_on) begin
                        if (presc_q == TICK_LAST) begin
                            presc_d = '0;
                            disp_d  = dec;
                            if (is_zero(dec) || dec_underflow) begin
                                state_d = DONE;
                            end
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (digit_ok) begin
                        disp_d  = shifted;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            disp_q       <= '0;
            presc_q      <= '0;
            timer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            presc_q      <= presc_d;
            timer_done_q <= (state_d == DONE);
        end
    end

    assign min_tens   = disp_q.min_tens;
    assign min_ones   = disp_q.min_ones;
    assign sec_tens   = disp_q.sec_tens;
    assign sec_ones   = disp_q.sec_ones;
    assign timer_done = timer_done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random keypad
// and magnetron activity, checked against an arithmetic model of the timer.
module tb_countdown_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_;
    logic       digit_valid;
    logic [3:0] digit;
    logic       mag_on;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_     (clear_),
        .digit_valid(digit_valid),
        .digit      (digit),
        .mag_on     (mag_on),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] disp;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Model: time is a 4-digit decimal entry MMSS; mode 0 idle, 1 running, 2 done.
    int m_num;
    int m_mode;
    int m_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] model_disp();
        int mins, secs;
        mins = m_num / 100;
        secs = m_num % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    function automatic logic [16:0] dut_out();
        return {min_tens, min_ones, sec_tens, sec_ones, timer_done};
    endfunction

    task automatic model_reset();
        m_num = 0; m_mode = 0; m_cycles = 0;
    endtask

    task automatic model_step(input logic dv, input logic [3:0] d, input logic mag, input logic clr_n);
        logic valid;
        valid = dv && (d <= 4'd9);
        if (!clr_n) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (mag) begin
                m_cycles = 0;
                m_mode   = (m_num == 0) ? 2 : 1;
            end else if (valid) begin
                m_num = (m_num * 10 + int'(d)) % 10000;
            end
        end else if (m_mode == 1) begin
            if (mag) begin
                m_cycles++;
                if (m_cycles == TD) begin
                    m_cycles = 0;
                    if (m_num % 100 > 0) m_num = m_num - 1;
                    else m_num = (m_num / 100 - 1) * 100 + 59;
                    if (m_num == 0) m_mode = 2;
                end
            end
        end else begin
            if (valid) begin
                m_num  = (m_num * 10 + int'(d)) % 10000;
                m_mode = 0;
            end
        end
    endtask

    // Called on a falling edge: drive inputs for the next rising edge and queue its outcome.
    task automatic step(input logic dv, input logic [3:0] d, input logic mag, input logic clr_n);
        exp_t e;
        digit_valid = dv;
        digit       = d;
        mag_on      = mag;
        clear_      = clr_n;
        model_step(dv, d, mag, clr_n);
        e.disp = model_disp();
        e.done = (m_mode == 2);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n, input logic mag);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, mag, 1'b1);
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic check_now(input string name, input logic [15:0] disp, input logic done);
        check(name, {15'd0, dut_out()}, {15'd0, disp, done});
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {15'd0, dut_out()}, {15'd0, e.disp, e.done});
        end
    end

    initial begin
        rst_n = 1'b0; clear_ = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
        model_reset();
        #1;
        check_now("reset_state", 16'h0000, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Entry 1,3,0 shows 01:30; an out-of-range key is ignored.
        key(4'd1); key(4'd3); key(4'hC); key(4'd0);
        check_now("entry_0130", 16'h0130, 1'b0);

        // First mag_on edge enters RUN; the next TD edges produce one second.
        idle_steps(1 + TD, 1'b1);
        check_now("run_0129", 16'h0129, 1'b0);
        idle_steps(2 * TD, 1'b1);
        check_now("run_0127", 16'h0127, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);

        // 00:01 counts to 00:00 and done holds while mag_on toggles.
        key(4'd1);
        idle_steps(1 + TD, 1'b1);
        check_now("done_0000", 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, logic'(i % 2), 1'b1);
        check_now("done_held", 16'h0000, 1'b1);

        // 10:00 -> 09:59 borrows through every digit in one edge.
        step(1'b0, 4'd0, 1'b0, 1'b0);
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        idle_steps(TD, 1'b1);
        check_now("pre_borrow", 16'h1000, 1'b0);
        idle_steps(1, 1'b1);
        check_now("borrow_0959", 16'h0959, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);

        // Pause with prescaler at 2 holds; decrement lands 2 cycles after resume.
        key(4'd5);
        idle_steps(3, 1'b1);
        idle_steps(10, 1'b0);
        check_now("paused_0005", 16'h0005, 1'b0);
        idle_steps(1, 1'b1);
        check_now("resume_1", 16'h0005, 1'b0);
        idle_steps(1, 1'b1);
        check_now("resume_2", 16'h0004, 1'b0);

        // Zero time with mag_on goes straight to DONE; clear beats a digit there.
        step(1'b0, 4'd0, 1'b0, 1'b0);
        idle_steps(1, 1'b1);
        check_now("idle_to_done", 16'h0000, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        check_now("clear_priority", 16'h0000, 1'b0);
        idle_steps(1, 1'b1);
        key(4'd9);
        check_now("done_digit_exit", 16'h0009, 1'b0);
        key(4'd2);
        check_now("second_entry", 16'h0092, 1'b0);

        // Asynchronous reset mid-RUN zeroes outputs without a clock edge.
        idle_steps(3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 16'h0000, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mag_on = 1'b0;
        idle_steps(2, 1'b0);
        key(4'd2);
        idle_steps(1 + TD, 1'b1);
        check_now("after_reset_run", 16'h0001, 1'b0);

        // Random episodes: short entries, bursty magnetron, stray keys and rare clears.
        for (int ep = 0; ep < 25; ep++) begin
            int nkeys, len;
            step(1'b0, 4'd0, 1'b0, logic'($urandom_range(0, 3) != 0));
            nkeys = $urandom_range(1, 3);
            for (int k = 0; k < nkeys; k++) begin
                step(1'b1, 4'($urandom_range(0, 11)), 1'b0, 1'b1);
                if ($urandom_range(0, 2) == 0) idle_steps(1, 1'b0);
            end
            len = $urandom_range(40, 400);
            for (int c = 0; c < len; c++) begin
                step(logic'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                     logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 299) != 0));
            end
        end

        idle_steps(2, 1'b0);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
